hash_target_scanner: RTL

- Parametrised successor to the fixed 24-bit / 2-byte / hard-wired-target comparator in the hash-generator datapath.
- Sits after the hash core. Accepts one (hash, nonce) pair per cycle and tests the top NUM_CMP bytes of the hash against a runtime-loadable target.
- Reports winning hashes ("bounties") through a valid/ready output buffer.
- Adds start/stop control, a stop-on-first-hit mode, a hit counter and overrun detection.

---
 rtl/hash_pkg.sv | 19 +
 rtl/hash_target_scanner_if.sv | 24 ++
 rtl/byte_lt_cmp.sv | 17 +
 rtl/hash_target_scanner.sv | 111 +++++++++++
 4 files changed

// File: rtl/hash_pkg.sv
// Shared types and constants for the hash target scanner: state encoding,
// byte width, default target and a configuration legality check.
package hash_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] TARGET_DEFAULT = 8'h40;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_FOUND  = 2'd2
  } state_t;

  // Hash must be whole bytes and the compare window must fit inside it.
  function automatic bit cfg_ok(int hash_w, int num_cmp);
    return (hash_w % BYTE_W == 0) && (num_cmp >= 1) && (num_cmp <= hash_w / BYTE_W);
  endfunction

endpackage

// File: rtl/hash_target_scanner_if.sv
// Input beat stream and bounty output stream of the scanner.
interface hash_target_scanner_if #(
  parameter int HASH_W  = 24,
  parameter int NONCE_W = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [HASH_W-1:0]  in_hash;
  logic [NONCE_W-1:0] in_nonce;
  logic               out_valid;
  logic               out_ready;
  logic [HASH_W-1:0]  bounty;
  logic [NONCE_W-1:0] bounty_nonce;

  modport master (
    output in_valid, in_hash, in_nonce, out_ready,
    input  in_ready, out_valid, bounty, bounty_nonce
  );

  modport slave (
    input  in_valid, in_hash, in_nonce, out_ready,
    output in_ready, out_valid, bounty, bounty_nonce
  );
endinterface

// File: rtl/byte_lt_cmp.sv
// Per-byte unsigned less-than against the target; bit k covers byte k
// counted from the MSB end of the compared window.
module byte_lt_cmp
  import hash_pkg::*;
#(
  parameter int NUM_CMP = 2
) (
  input  logic [NUM_CMP*BYTE_W-1:0] hash,
  input  logic [BYTE_W-1:0]         target,
  output logic [NUM_CMP-1:0]        lt
);

  for (genvar k = 0; k < NUM_CMP; k++) begin : g_byte
    assign lt[k] = hash[(NUM_CMP-k)*BYTE_W-1 -: BYTE_W] < target;
  end

endmodule

// File: rtl/hash_target_scanner.sv
// Two-stage hash/target scanner: S1 holds the per-byte compare vector, S2 is
// the bounty buffer written directly by the AND-reduced S1 hit.
module hash_target_scanner
  import hash_pkg::*;
#(
  parameter int                HASH_W        = 24,
  parameter int                NUM_CMP       = 2,
  parameter int                NONCE_W       = 32,
  parameter logic [BYTE_W-1:0] TARGET_RST    = TARGET_DEFAULT,
  parameter bit                STOP_ON_FIRST = 1'b1,
  parameter int                CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  target_wr,
  input  logic [BYTE_W-1:0]     target_in,
  hash_target_scanner_if.slave  bus,
  output logic [CNT_W-1:0]      hit_cnt,
  output logic                  overrun,
  output logic                  busy
);

  localparam int CMP_W = NUM_CMP * BYTE_W;

  if (!cfg_ok(HASH_W, NUM_CMP)) begin : g_bad_cfg
    $error("hash_target_scanner: HASH_W must be a multiple of 8 and NUM_CMP in 1..HASH_W/8");
  end

  state_t               state, state_nxt;
  logic [BYTE_W-1:0]    target;
  logic [NUM_CMP-1:0]   lt_in, s1_lt;
  logic                 s1_vld;
  logic [HASH_W-1:0]    s1_hash;
  logic [NONCE_W-1:0]   s1_nonce;
  logic                 searching, accept, load;

  assign searching    = (state == ST_SEARCH);
  assign bus.in_ready = searching;
  assign accept       = bus.in_valid & searching;
  // An abort on the same cycle as an emerging hit drops that hit.
  assign load         = s1_vld & (&s1_lt) & searching & ~abort;
  assign busy         = (state != ST_IDLE);

  byte_lt_cmp #(.NUM_CMP(NUM_CMP)) u_cmp (
    .hash   (bus.in_hash[HASH_W-1 -: CMP_W]),
    .target (target),
    .lt     (lt_in)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (start) state_nxt = ST_SEARCH;
      ST_SEARCH: if (load && STOP_ON_FIRST) state_nxt = ST_FOUND;
      ST_FOUND:  if (bus.out_valid && bus.out_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset)          target <= TARGET_RST;
    else if (target_wr) target <= target_in;
  end

  // Beats trailing a stop-mode winner are flushed rather than reported.
  always_ff @(posedge clk) begin
    if (reset) s1_vld <= 1'b0;
    else       s1_vld <= accept & ~abort & ~(load & STOP_ON_FIRST);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_lt    <= lt_in;
      s1_hash  <= bus.in_hash;
      s1_nonce <= bus.in_nonce;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid    <= 1'b0;
      bus.bounty       <= '0;
      bus.bounty_nonce <= '0;
      hit_cnt          <= '0;
      overrun          <= 1'b0;
    end else begin
      if (load) begin
        bus.out_valid    <= 1'b1;
        bus.bounty       <= s1_hash;
        bus.bounty_nonce <= s1_nonce;
        if (bus.out_valid && !bus.out_ready) overrun <= 1'b1;
        if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      if (state == ST_IDLE && start && !abort) begin
        hit_cnt <= '0;
        overrun <= 1'b0;
      end
    end
  end

endmodule
